cache_drain_scheduler: RTL and testbench

CACHE_DRAIN_SCHEDULER -- requirements
Module: cache_drain_scheduler

---
 rtl/cache_drain_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_cache_drain_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cache_drain_scheduler
// Description : Frame-driven sweep over SENSOR_NUM per-sensor cache FIFOs.
//               On each start pulse, every channel is visited in order. A
//               channel holding at least BURST_LEN bytes (and not empty) has
//               BURST_LEN bytes moved into the upstream byte stream. Channels
//               with less data are skipped and counted. Reads are throttled
//               by the upstream programmable-full flag and the channel's
//               empty flag.
//
//               Optional build macro SCHED_CHANNEL_HDR_EN: when defined, each
//               burst is preceded by one header byte carrying the channel
//               index. When undefined, the upstream stream carries data only.
//
// Ports       : sys_clk_i        - clock, rising edge
//               rst_i            - asynchronous active-high reset
//               start_pluse_i    - one-cycle frame start
//               empty_i          - per-channel FIFO empty
//               data_count_i     - per-channel byte count, 16 bits each
//               din_i            - per-channel read data, 8 bits each,
//                                  valid the cycle after rd_en_o
//               rd_en_o          - per-channel read strobe (one-hot or zero)
//               us_wr_en_o       - upstream byte-write strobe
//               us_wr_dout_o     - upstream byte
//               us_prog_full_i   - upstream programmable full
//               busy_o           - sweep in progress
//               done_pluse_o     - one-cycle sweep-complete pulse
//               skip_cnt_o       - skipped channels, saturating
//               overrun_cnt_o    - starts received while busy, saturating
//
// Revision    : 1.0 - initial release
// ============================================================================
module cache_drain_scheduler #(
    parameter int SENSOR_NUM = 22,
    parameter int BURST_LEN  = 100
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic                     start_pluse_i,
    input  logic [SENSOR_NUM-1:0]    empty_i,
    input  logic [SENSOR_NUM*16-1:0] data_count_i,
    input  logic [SENSOR_NUM*8-1:0]  din_i,
    output logic [SENSOR_NUM-1:0]    rd_en_o,
    output logic                     us_wr_en_o,
    output logic [7:0]               us_wr_dout_o,
    input  logic                     us_prog_full_i,
    output logic                     busy_o,
    output logic                     done_pluse_o,
    output logic [15:0]              skip_cnt_o,
    output logic [7:0]               overrun_cnt_o
);

    localparam logic [2:0]  c_ST_IDLE  = 3'd0;
    localparam logic [2:0]  c_ST_CHECK = 3'd1;
`ifdef SCHED_CHANNEL_HDR_EN
    localparam logic [2:0]  c_ST_HDR   = 3'd2;
`endif
    localparam logic [2:0]  c_ST_READ  = 3'd3;
    localparam logic [2:0]  c_ST_DRAIN = 3'd4;
    localparam logic [2:0]  c_ST_NEXT  = 3'd5;
    localparam logic [2:0]  c_ST_DONE  = 3'd6;

    localparam logic [15:0] c_BURST    = 16'(BURST_LEN);
    localparam logic [15:0] c_BURST_M1 = 16'(BURST_LEN - 1);
    localparam logic [7:0]  c_LAST_CH  = 8'(SENSOR_NUM - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_ch;
    logic [15:0] r_cnt;
    logic [15:0] r_skip;
    logic [7:0]  r_ovr;
    logic        r_busy;
    logic        r_data_wr;   // a read strobe fired last cycle; its byte is on din_i now

    logic [2:0]  w_next;
    logic [15:0] w_sel_cnt;
    logic        w_sel_empty;
    logic [7:0]  w_sel_din;
    logic        w_ch_ok;
    logic        w_rd_fire;
    logic        w_hdr_wr;

    // Per-channel selection by the current channel index.
    always_comb begin
        w_sel_cnt   = '0;
        w_sel_empty = 1'b1;
        w_sel_din   = '0;
        for (int k = 0; k < SENSOR_NUM; k++) begin
            if (r_ch == 8'(k)) begin
                w_sel_cnt   = data_count_i[k*16 +: 16];
                w_sel_empty = empty_i[k];
                w_sel_din   = din_i[k*8 +: 8];
            end
        end
    end

    assign w_ch_ok   = (w_sel_cnt >= c_BURST) && !w_sel_empty;
    assign w_rd_fire = (r_state == c_ST_READ) && !us_prog_full_i &&
                       (r_cnt < c_BURST) && !w_sel_empty;

`ifdef SCHED_CHANNEL_HDR_EN
    assign w_hdr_wr  = (r_state == c_ST_HDR) && !us_prog_full_i;
`else
    assign w_hdr_wr  = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start_pluse_i) w_next = c_ST_CHECK;
            c_ST_CHECK: begin
                if (w_ch_ok) begin
`ifdef SCHED_CHANNEL_HDR_EN
                    w_next = c_ST_HDR;
`else
                    w_next = c_ST_READ;
`endif
                end else begin
                    w_next = c_ST_NEXT;
                end
            end
`ifdef SCHED_CHANNEL_HDR_EN
            c_ST_HDR:   if (!us_prog_full_i) w_next = c_ST_READ;
`endif
            // Leave after the final strobe; DRAIN lets its byte be written.
            c_ST_READ:  if (w_rd_fire && (r_cnt == c_BURST_M1)) w_next = c_ST_DRAIN;
            c_ST_DRAIN: w_next = c_ST_NEXT;
            c_ST_NEXT:  w_next = (r_ch == c_LAST_CH) ? c_ST_DONE : c_ST_CHECK;
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= c_ST_IDLE;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_skip    <= '0;
            r_ovr     <= '0;
            r_busy    <= 1'b0;
            r_data_wr <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next != c_ST_IDLE);
            r_data_wr <= w_rd_fire;

            if ((r_state == c_ST_IDLE) && start_pluse_i) begin
                r_ch <= '0;
            end else if ((r_state == c_ST_NEXT) && (r_ch != c_LAST_CH)) begin
                r_ch <= r_ch + 8'd1;
            end

            if (r_state == c_ST_CHECK) begin
                r_cnt <= '0;
            end else if (w_rd_fire) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if ((r_state == c_ST_CHECK) && !w_ch_ok && (r_skip != 16'hFFFF)) begin
                r_skip <= r_skip + 16'd1;
            end

            if (start_pluse_i && (r_state != c_ST_IDLE) && (r_ovr != 8'hFF)) begin
                r_ovr <= r_ovr + 8'd1;
            end
        end
    end

    always_comb begin
        rd_en_o = '0;
        for (int k = 0; k < SENSOR_NUM; k++) begin
            rd_en_o[k] = w_rd_fire && (r_ch == 8'(k));
        end
    end

    // Header and data writes never coincide: the header precedes any read
    // and DRAIN completes the final data write before the channel advances.
    assign us_wr_en_o    = r_data_wr | w_hdr_wr;
    assign us_wr_dout_o  = r_data_wr ? w_sel_din : (w_hdr_wr ? r_ch : 8'h00);
    assign busy_o        = r_busy;
    assign done_pluse_o  = (r_state == c_ST_DONE);
    assign skip_cnt_o    = r_skip;
    assign overrun_cnt_o = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_cache_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_drain_scheduler
// Description : Self-checking bench for cache_drain_scheduler. A FIFO model
//               supplies per-channel byte patterns; a queue of expected
//               upstream bytes is built from the sweep rules at each start
//               and compared with every upstream write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_drain_scheduler;

    localparam int N = 22;
    localparam int B = 100;
`ifdef SCHED_CHANNEL_HDR_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif
    localparam int FULL_SWEEP_WR = (H == 1) ? 2222 : 2200;
    localparam int SKIP5_WR      = (H == 1) ? 2121 : 2100;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           start = 1'b0;
    logic           pf    = 1'b0;
    logic [N-1:0]   empty = '0;
    logic [N*16-1:0] dcount = '0;
    logic [N*8-1:0] din;
    logic [N-1:0]   rd_en;
    logic           wr_en;
    logic [7:0]     wr_dout;
    logic           busy;
    logic           done;
    logic [15:0]    skip_cnt;
    logic [7:0]     ovr_cnt;

    cache_drain_scheduler #(.SENSOR_NUM(N), .BURST_LEN(B)) dut (
        .sys_clk_i      (clk),
        .rst_i          (rst),
        .start_pluse_i  (start),
        .empty_i        (empty),
        .data_count_i   (dcount),
        .din_i          (din),
        .rd_en_o        (rd_en),
        .us_wr_en_o     (wr_en),
        .us_wr_dout_o   (wr_dout),
        .us_prog_full_i (pf),
        .busy_o         (busy),
        .done_pluse_o   (done),
        .skip_cnt_o     (skip_cnt),
        .overrun_cnt_o  (ovr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(int k, int i);
        return 8'((k * 10 + i) & 255);
    endfunction

    // FIFO model: a strobe seen in one cycle presents the next byte the cycle after.
    logic [7:0]   din_mem [N] = '{default: 8'h00};
    int           rdptr   [N] = '{default: 0};
    logic [N-1:0] pend = '0;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (pend[k]) begin
                din_mem[k] <= pat(k, rdptr[k]);
                rdptr[k]   <= rdptr[k] + 1;
            end
        end
    end

    always_comb begin
        din = '0;
        for (int k = 0; k < N; k++) din[k*8 +: 8] = din_mem[k];
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         exp_rd = 0;
    int         wr_total = 0;
    int         done_total = 0;
    int         rd_cnt [N] = '{default: 0};
    int         first_rd_ch = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the expected stream.
    task automatic compare();
        pend = rst ? '0 : rd_en;
        if (rst) begin
            exp_rd      = exp_q.size();
            first_rd_ch = -1;
        end else begin
            chk("rd_onehot", longint'($countones(rd_en) <= 1), 1);
            chk("rd_to_empty", longint'(|(rd_en & empty)), 0);
            if (pf) chk("rd_while_full", longint'(|rd_en), 0);
            for (int k = 0; k < N; k++) begin
                if (rd_en[k]) begin
                    rd_cnt[k]++;
                    if (first_rd_ch < 0) first_rd_ch = k;
                end
            end
            if (done) done_total++;
            if (wr_en) begin
                wr_total++;
                chk("write_expected", longint'(exp_rd < exp_q.size()), 1);
                if (exp_rd < exp_q.size()) begin
                    chk("stream_byte", wr_dout, exp_q[exp_rd]);
                    exp_rd++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic set_counts(input int v);
        for (int k = 0; k < N; k++) dcount[k*16 +: 16] = 16'(v);
    endtask

    task automatic start_sweep();
        for (int k = 0; k < N; k++) begin
            if (int'(dcount[k*16 +: 16]) >= B && !empty[k]) begin
                if (H == 1) exp_q.push_back(8'(k));
                for (int i = 0; i < B; i++) exp_q.push_back(pat(k, rdptr[k] + i));
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        for (int c = 0; c < 4000; c++) begin
            if (done) break;
            tick();
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 1);
        chk("queue_drained_at_done", exp_q.size() - exp_rd, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    int base_wr, base_done, base3, base7, hold, base5, base0;

    initial begin
        #1;
        chk("reset_rd_en", rd_en, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_dout", wr_dout, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_skip", skip_cnt, 0);
        chk("reset_overrun", ovr_cnt, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Full sweep, every channel ready.
        set_counts(100);
        base_wr = wr_total; base0 = rd_cnt[0];
        start_sweep();
        wait_done();
        chk("t35_writes", wr_total - base_wr, FULL_SWEEP_WR);
        chk("t35_rd_ch0", rd_cnt[0] - base0, 100);
        chk("t35_skip", skip_cnt, 0);

        // Channel 5 one byte short.
        dcount[5*16 +: 16] = 16'd99;
        base_wr = wr_total; base5 = rd_cnt[5];
        start_sweep();
        wait_done();
        chk("t36_writes", wr_total - base_wr, SKIP5_WR);
        chk("t36_rd_ch5", rd_cnt[5] - base5, 0);
        chk("t36_skip", skip_cnt, 1);

        // Upstream full mid-burst on channel 3, empty mid-burst on channel 7.
        set_counts(100);
        base_wr = wr_total; base3 = rd_cnt[3]; base7 = rd_cnt[7];
        start_sweep();
        for (int c = 0; c < 2000 && (rd_cnt[3] - base3) < 40; c++) tick();
        pf = 1'b1;
        #1;
        chk("t37_inflight_write", wr_en, 1);
        chk("t37_rd_paused", rd_en, 0);
        hold = rd_cnt[3];
        repeat (10) tick();
        chk("t37_no_reads_while_full", rd_cnt[3], hold);
        pf = 1'b0;
        for (int c = 0; c < 2000 && (rd_cnt[7] - base7) < 20; c++) tick();
        empty[7] = 1'b1;
        hold = rd_cnt[7];
        repeat (5) tick();
        chk("t37_no_reads_while_empty", rd_cnt[7], hold);
        empty[7] = 1'b0;
        wait_done();
        chk("t37_writes", wr_total - base_wr, FULL_SWEEP_WR);
        chk("t37_rd_ch3", rd_cnt[3] - base3, 100);
        chk("t37_rd_ch7", rd_cnt[7] - base7, 100);

        // Second start while busy.
        base_wr = wr_total; base_done = done_total;
        start_sweep();
        repeat (49) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t38_overrun", ovr_cnt, 1);
        wait_done();
        repeat (300) tick();
        chk("t38_writes", wr_total - base_wr, FULL_SWEEP_WR);
        chk("t38_done_pulses", done_total - base_done, 1);
        chk("t38_idle", busy, 0);

        // Reset while reading channel 2.
        base3 = rd_cnt[2];
        start_sweep();
        for (int c = 0; c < 2000 && (rd_cnt[2] - base3) < 10; c++) tick();
        rst = 1'b1;
        #1;
        chk("t39_rd_en", rd_en, 0);
        chk("t39_wr_en", wr_en, 0);
        chk("t39_dout", wr_dout, 0);
        chk("t39_busy", busy, 0);
        chk("t39_done", done, 0);
        chk("t39_skip", skip_cnt, 0);
        chk("t39_overrun", ovr_cnt, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t39_no_write_after_reset", wr_en, 0);
        base_wr = wr_total;
        start_sweep();
        wait_done();
        chk("t39_first_rd_ch", first_rd_ch, 0);
        chk("t39_writes", wr_total - base_wr, FULL_SWEEP_WR);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
